jbus_txn_capture: RTL and testbench

JBUS_TXN_CAPTURE -- requirements
Module: jbus_txn_capture

---
 rtl/jbus_txn_capture.sv | 206 ++++++++++++++++++++
 tb/tb_jbus_txn_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jbus_txn_capture.sv
// jbus_txn_capture: decodes JBus address/data cycles into transaction records held in a small FIFO.
// Define JBUS_CAP_PARITY_EN to compile in per-lane parity checking (rec_err[0]).
module jbus_txn_capture #(
    parameter int DEPTH = 4
) (
    input  logic         jbus_j_clk,
    input  logic         jbus_j_rst_l,
    input  logic [127:0] jbus_j_ad,
    input  logic [7:0]   jbus_j_adtype,
    input  logic [3:0]   jbus_j_adp,
    output logic         rec_valid,
    input  logic         rec_ready,
    output logic [4:0]   rec_type,
    output logic [42:0]  rec_addr,
    output logic [1:0]   rec_err,
    input  logic         clr,
    output logic         ovf_sticky,
    output logic [7:0]   stray_cnt,
    output logic         bus_idle
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  typ;
        logic [42:0] addr;
        logic [1:0]  err;
    } rec_t;

    state_e        state_q, state_d;
    logic [2:0]    beat_q, beat_d;
    rec_t          open_q, open_d;
    rec_t          pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    rec_t          head_q, head_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    stray_q, stray_d;

    logic          is_addr, is_data, perr_now, stray_inc;
    logic [4:0]    ad_type;
    rec_t          new_rec, req_a, req_b, push_rec;
    logic          req_a_vld, req_b_vld, push_vld, push_ok, pop;

    assign is_addr = (jbus_j_adtype == 8'h01);
    assign is_data = (jbus_j_adtype == 8'h02);
    assign ad_type = jbus_j_ad[68:64];

`ifdef JBUS_CAP_PARITY_EN
    always_comb begin
        perr_now = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (jbus_j_adp[i] != ^jbus_j_ad[32*i +: 32]) perr_now = 1'b1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{jbus_j_adp, jbus_j_ad[127:69], jbus_j_ad[63:43]};
    assign perr_now    = 1'b0;
`endif

    assign new_rec = '{typ: ad_type, addr: jbus_j_ad[42:0], err: {1'b0, perr_now}};

    // Transaction decode: up to two records can complete on one edge (truncation plus a new read).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        beat_d    = beat_q;
        open_d    = open_q;
        req_a     = '0;
        req_a_vld = 1'b0;
        req_b     = '0;
        req_b_vld = 1'b0;
        stray_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_addr) begin
                    if (ad_type[4]) begin
                        state_d = DATA;
                        beat_d  = {1'b0, ad_type[1:0]} + 3'd1;
                        open_d  = new_rec;
                    end else begin
                        req_a_vld = 1'b1;
                        req_a     = new_rec;
                    end
                end else if (is_data) begin
                    stray_inc = 1'b1;
                end
            end
            DATA: begin
                if (is_addr) begin
                    req_a_vld  = 1'b1;
                    req_a      = open_q;
                    req_a.err[1] = 1'b1;
                    if (ad_type[4]) begin
                        beat_d = {1'b0, ad_type[1:0]} + 3'd1;
                        open_d = new_rec;
                    end else begin
                        req_b_vld = 1'b1;
                        req_b     = new_rec;
                        state_d   = IDLE;
                        beat_d    = 3'd0;
                    end
                end else if (is_data) begin
                    open_d.err[0] = open_q.err[0] | perr_now;
                    beat_d        = beat_q - 3'd1;
                    if (beat_q == 3'd1) begin
                        req_a_vld = 1'b1;
                        req_a     = open_d;
                        state_d   = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // One push per edge; a second completed record waits one edge in the pending slot.
    // A pending record only exists in IDLE, where at most one new record can complete.
    always_comb begin
        if (pend_vld_q) begin
            push_vld   = 1'b1;
            push_rec   = pend_q;
            pend_vld_d = req_a_vld;
            pend_d     = req_a;
        end else begin
            push_vld   = req_a_vld;
            push_rec   = req_a;
            pend_vld_d = req_b_vld;
            pend_d     = req_b;
        end
    end

    assign rec_valid = (count_q != '0);
    assign pop       = rec_valid && rec_ready;
    assign push_ok   = push_vld && ((count_q != (AW+1)'(DEPTH)) || pop);
    assign wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    assign rd_ptr_d  = rd_ptr_q + AW'(pop);
    assign count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);

    // Head register holds the next head so rec_* are glitch-free and keep their value when empty.
    always_comb begin
        head_d = head_q;
        if (count_d != '0) begin
            if ((count_q - (AW+1)'(pop)) == '0) head_d = push_rec;
            else                                 head_d = mem_q[rd_ptr_d];
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push_vld && !push_ok) ovf_d = 1'b1;
        else if (clr)             ovf_d = 1'b0;
        stray_d = stray_q;
        if (stray_inc)            stray_d = (stray_q == 8'hFF) ? 8'hFF : stray_q + 8'd1;
        else if (clr)             stray_d = 8'h00;
    end

    always_ff @(posedge jbus_j_clk or negedge jbus_j_rst_l) begin
        if (!jbus_j_rst_l) begin
            state_q    <= IDLE;
            beat_q     <= 3'd0;
            open_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            ovf_q      <= 1'b0;
            stray_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            open_q     <= open_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
            stray_q    <= stray_d;
        end
    end

    // NOTE: storage is not reset; occupancy and pointers define validity, so stale entries are never read.
    always_ff @(posedge jbus_j_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_rec;
    end

    assign rec_type   = head_q.typ;
    assign rec_addr   = head_q.addr;
    assign rec_err    = head_q.err;
    assign ovf_sticky = ovf_q;
    assign stray_cnt  = stray_q;
    assign bus_idle   = (state_q == IDLE) && (count_q == '0) && !pend_vld_q;

endmodule

// File: tb/tb_jbus_txn_capture.sv
// Self-checking bench for jbus_txn_capture: directed scenarios plus random traffic against a
// transaction-level queue model.
module tb_jbus_txn_capture;

    localparam int DEPTH = 4;
`ifdef JBUS_CAP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  typ;
        logic [42:0] addr;
        logic [1:0]  err;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [127:0] ad = '0;
    logic [7:0]   adtype = '0;
    logic [3:0]   adp = '0;
    logic         ready = 1'b0;
    logic         clr = 1'b0;
    logic         rec_valid, ovf_sticky, bus_idle;
    logic [4:0]   rec_type;
    logic [42:0]  rec_addr;
    logic [1:0]   rec_err;
    logic [7:0]   stray_cnt;

    int checks = 0;
    int failures = 0;

    bit   m_open;
    int   m_left;
    rec_t m_rec;
    rec_t m_pend[$];
    rec_t m_fifo[$];
    bit   m_ovf;
    int   m_stray;

    always #5 clk = ~clk;

    jbus_txn_capture #(.DEPTH(DEPTH)) dut (
        .jbus_j_clk   (clk),
        .jbus_j_rst_l (rst_l),
        .jbus_j_ad    (ad),
        .jbus_j_adtype(adtype),
        .jbus_j_adp   (adp),
        .rec_valid    (rec_valid),
        .rec_ready    (ready),
        .rec_type     (rec_type),
        .rec_addr     (rec_addr),
        .rec_err      (rec_err),
        .clr          (clr),
        .ovf_sticky   (ovf_sticky),
        .stray_cnt    (stray_cnt),
        .bus_idle     (bus_idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lane_par(input logic [127:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[32*i +: 32];
        return p;
    endfunction

    task automatic model_reset();
        m_open = 0;
        m_left = 0;
        m_rec  = '0;
        m_pend.delete();
        m_fifo.delete();
        m_ovf   = 0;
        m_stray = 0;
    endtask

    // Applies the transaction rules to the inputs sampled at this edge.
    task automatic model_edge();
        rec_t reqs[$];
        rec_t r;
        bit   perr, inc, drop;
        perr = PAR_EN && (adp != lane_par(ad));
        inc  = 0;
        drop = 0;
        if (adtype == 8'h01) begin
            if (m_open) begin
                r = m_rec;
                r.err[1] = 1'b1;
                reqs.push_back(r);
                m_open = 0;
            end
            r = '{typ: ad[68:64], addr: ad[42:0], err: {1'b0, perr}};
            if (r.typ[4]) begin
                m_open = 1;
                m_left = int'(r.typ[1:0]) + 1;
                m_rec  = r;
            end else begin
                reqs.push_back(r);
            end
        end else if (adtype == 8'h02) begin
            if (m_open) begin
                m_rec.err[0] = m_rec.err[0] | perr;
                m_left--;
                if (m_left == 0) begin
                    reqs.push_back(m_rec);
                    m_open = 0;
                end
            end else begin
                inc = 1;
            end
        end
        foreach (reqs[i]) m_pend.push_back(reqs[i]);
        if (m_fifo.size() != 0 && ready) void'(m_fifo.pop_front());
        if (m_pend.size() != 0) begin
            r = m_pend.pop_front();
            if (m_fifo.size() < DEPTH) m_fifo.push_back(r);
            else drop = 1;
        end
        if (inc) begin
            if (m_stray < 255) m_stray++;
        end else if (clr) begin
            m_stray = 0;
        end
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic compare();
        check("rec_valid", 64'(rec_valid), 64'(m_fifo.size() != 0));
        check("bus_idle", 64'(bus_idle), 64'(!m_open && m_fifo.size() == 0 && m_pend.size() == 0));
        check("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
        check("stray_cnt", 64'(stray_cnt), 64'(m_stray));
        if (m_fifo.size() != 0) begin
            check("rec_type", 64'(rec_type), 64'(m_fifo[0].typ));
            check("rec_addr", 64'(rec_addr), 64'(m_fifo[0].addr));
            check("rec_err", 64'(rec_err), 64'(m_fifo[0].err));
        end
    endtask

    task automatic cycle(input logic [7:0] t, input logic [4:0] typ, input logic [42:0] addr,
                         input logic [3:0] flip, input logic rdy, input logic c);
        logic [127:0] d;
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        d[68:64] = typ;
        d[42:0]  = addr;
        ad     = d;
        adtype = t;
        adp    = lane_par(d) ^ flip;
        ready  = rdy;
        clr    = c;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input logic rdy);
        cycle(8'h00, 5'h00, 43'h0, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int rdy_pct;
        logic [7:0] t;
        int r;
        model_reset();
        #12;
        check("rst_rec_valid", 64'(rec_valid), 64'd0);
        check("rst_rec_type", 64'(rec_type), 64'd0);
        check("rst_rec_addr", 64'(rec_addr), 64'd0);
        check("rst_rec_err", 64'(rec_err), 64'd0);
        check("rst_ovf", 64'(ovf_sticky), 64'd0);
        check("rst_stray", 64'(stray_cnt), 64'd0);
        check("rst_bus_idle", 64'(bus_idle), 64'd1);
        @(negedge clk);
        rst_l = 1'b1;

        // Single read, visible the cycle after its edge, gone after one pop.
        cycle(8'h01, 5'h03, 43'h1234, 4'h0, 1'b0, 1'b0);
        check("read_valid", 64'(rec_valid), 64'd1);
        check("read_type", 64'(rec_type), 64'h03);
        check("read_addr", 64'(rec_addr), 64'h1234);
        check("read_err", 64'(rec_err), 64'd0);
        idle(1'b1);
        check("read_popped", 64'(rec_valid), 64'd0);

        // Three-beat write with an idle gap between beats.
        cycle(8'h01, 5'h12, 43'h4_0000_0abc, 4'h0, 1'b0, 1'b0);
        cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b0, 1'b0);
        idle(1'b0);
        cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b0, 1'b0);
        check("write_not_yet", 64'(rec_valid), 64'd0);
        cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b0, 1'b0);
        check("write_valid", 64'(rec_valid), 64'd1);
        check("write_busy", 64'(bus_idle), 64'd0);
        idle(1'b1);
        check("write_idle_after_pop", 64'(bus_idle), 64'd1);

        // Truncated write followed by a read address cycle.
        cycle(8'h01, 5'h13, 43'h111, 4'h0, 1'b0, 1'b0);
        cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b0, 1'b0);
        cycle(8'h01, 5'h01, 43'h222, 4'h0, 1'b0, 1'b0);
        check("trunc_err", 64'(rec_err), 64'h2);
        check("trunc_type", 64'(rec_type), 64'h13);
        idle(1'b1);
        check("after_trunc_type", 64'(rec_type), 64'h01);
        check("after_trunc_err", 64'(rec_err), 64'h0);
        idle(1'b1);
        check("trunc_drained", 64'(rec_valid), 64'd0);

        // Overflow on a full FIFO, then the same with a pop on the fifth push edge.
        for (int i = 0; i < 5; i++) cycle(8'h01, 5'h04, 43'(i + 16), 4'h0, 1'b0, 1'b0);
        check("ovf_set", 64'(ovf_sticky), 64'd1);
        check("ovf_head_intact", 64'(rec_addr), 64'd16);
        for (int i = 0; i < 4; i++) idle(1'b1);
        cycle(8'h00, 5'h00, 43'h0, 4'h0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(ovf_sticky), 64'd0);
        for (int i = 0; i < 4; i++) cycle(8'h01, 5'h05, 43'(i + 32), 4'h0, 1'b0, 1'b0);
        cycle(8'h01, 5'h05, 43'd36, 4'h0, 1'b1, 1'b0);
        check("no_drop_with_pop", 64'(ovf_sticky), 64'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Stray data cycles saturate, clr empties the counter.
        for (int i = 0; i < 300; i++) cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b1, 1'b0);
        check("stray_sat", 64'(stray_cnt), 64'hFF);
        cycle(8'h00, 5'h00, 43'h0, 4'h0, 1'b1, 1'b1);
        check("stray_clr", 64'(stray_cnt), 64'h0);

        // Parity error on lane 2 of a data beat.
        cycle(8'h01, 5'h10, 43'h55, 4'h0, 1'b0, 1'b0);
        cycle(8'h02, 5'h00, 43'h0, 4'b0100, 1'b0, 1'b0);
        check("parity_err0", 64'(rec_err[0]), 64'(PAR_EN));
        idle(1'b1);

        // Random traffic with varying consumer back-pressure.
        rdy_pct = 50;
        for (int n = 0; n < 2000; n++) begin
            if (n % 200 == 0) rdy_pct = $urandom_range(0, 100);
            r = $urandom_range(0, 9);
            t = (r < 3) ? 8'h01 : (r < 7) ? 8'h02 : (r < 9) ? 8'h00 : 8'h5A;
            cycle(t, 5'($urandom), 43'({$urandom, $urandom}),
                  ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0,
                  $urandom_range(0, 99) < rdy_pct,
                  (t != 8'h02) && ($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Asynchronous reset in the middle of a write with two records queued.
        cycle(8'h01, 5'h06, 43'h61, 4'h0, 1'b0, 1'b0);
        cycle(8'h01, 5'h07, 43'h62, 4'h0, 1'b0, 1'b0);
        cycle(8'h01, 5'h12, 43'h63, 4'h0, 1'b0, 1'b0);
        cycle(8'h02, 5'h00, 43'h0, 4'h0, 1'b0, 1'b0);
        check("pre_reset_valid", 64'(rec_valid), 64'd1);
        @(negedge clk);
        adtype = 8'h00;
        #2;
        rst_l = 1'b0;
        #1;
        check("async_rst_valid", 64'(rec_valid), 64'd0);
        check("async_rst_idle", 64'(bus_idle), 64'd1);
        check("async_rst_type", 64'(rec_type), 64'd0);
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        cycle(8'h01, 5'h05, 43'h77, 4'h0, 1'b0, 1'b0);
        check("post_rst_type", 64'(rec_type), 64'h05);
        check("post_rst_addr", 64'(rec_addr), 64'h77);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
